// File: rtl/vsync_frame_timer.sv
// rtl/vsync_frame_timer.sv - vsync-driven frame prescaler and up/down display counter
module vsync_frame_timer #(
    parameter int COUNT_W         = 8,
    parameter int MAX_COUNT       = 254,
    parameter int FRAMES_PER_TICK = 60,
    parameter int EDGE_SEL        = 0
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic               ivsync,
    input  logic               ien,
    input  logic               iclr,
    input  logic               iload,
    input  logic [COUNT_W-1:0] iload_val,
    input  logic [1:0]         imode,
    input  logic [COUNT_W-1:0] icmp_val,
    output logic [COUNT_W-1:0] oCount,
    output logic               oTick,
    output logic               oWrap,
    output logic               oSat,
    output logic               oMatch
);

    // Prescaler needs at least one bit even when every frame is a tick.
    localparam int PRE_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(FRAMES_PER_TICK - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ZERO = '0;

    localparam logic [1:0] MODE_UP_WRAP   = 2'b00;
    localparam logic [1:0] MODE_UP_SAT    = 2'b01;
    localparam logic [1:0] MODE_DOWN_WRAP = 2'b10;
    localparam logic [1:0] MODE_DOWN_SAT  = 2'b11;

    logic               vs_s1;
    logic               vs_s2;
    logic               vs_s3;
    logic               vs_rise;
    logic               vs_fall;
    logic               vs_edge;
    logic               frame_adv;
    logic               pre_term;
    logic [PRE_W-1:0]   pre_cnt;
    logic [COUNT_W-1:0] step_val;
    logic               step_wrap;
    logic [COUNT_W-1:0] load_clamped;

    // Two-flop synchroniser for the asynchronous vsync plus one edge-history flop.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= ivsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    // A held vsync level produces exactly one edge, so frames are counted once each.
    assign vs_rise   = vs_s2 & ~vs_s3;
    assign vs_fall   = ~vs_s2 & vs_s3;
    assign vs_edge   = (EDGE_SEL != 0) ? vs_fall : vs_rise;
    assign frame_adv = vs_edge & ien;
    assign pre_term  = frame_adv && (pre_cnt == PRE_LAST);

    // Loads are clamped so the count can never leave 0..MAX_COUNT.
    assign load_clamped = (iload_val > CNT_MAX) ? CNT_MAX : iload_val;

    // Frame prescaler: clear/load restart it, otherwise it advances per enabled frame edge.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            pre_cnt <= '0;
        end else if (iclr || iload) begin
            pre_cnt <= '0;
        end else if (frame_adv) begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_ONE;
            end
        end
    end

    // Next count for a step, chosen by the mode sampled in the step cycle.
    always_comb begin
        step_val  = oCount;
        step_wrap = 1'b0;
        case (imode)
            MODE_UP_WRAP: begin
                if (oCount == CNT_MAX) begin
                    step_val  = CNT_ZERO;
                    step_wrap = 1'b1;
                end else begin
                    step_val = oCount + CNT_ONE;
                end
            end
            MODE_UP_SAT: begin
                if (oCount != CNT_MAX) begin
                    step_val = oCount + CNT_ONE;
                end
            end
            MODE_DOWN_WRAP: begin
                if (oCount == CNT_ZERO) begin
                    step_val  = CNT_MAX;
                    step_wrap = 1'b1;
                end else begin
                    step_val = oCount - CNT_ONE;
                end
            end
            MODE_DOWN_SAT: begin
                if (oCount != CNT_ZERO) begin
                    step_val = oCount - CNT_ONE;
                end
            end
            default: begin
                step_val  = oCount;
                step_wrap = 1'b0;
            end
        endcase
    end

    // Display counter with clear > load > step priority and registered status pulses.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            oCount <= '0;
            oTick  <= 1'b0;
            oWrap  <= 1'b0;
        end else begin
            oTick <= 1'b0;
            oWrap <= 1'b0;
            if (iclr) begin
                oCount <= '0;
            end else if (iload) begin
                oCount <= load_clamped;
            end else if (pre_term) begin
                oCount <= step_val;
                oTick  <= 1'b1;
                oWrap  <= step_wrap;
            end
        end
    end

    // Status levels follow the live mode and count.
    assign oSat   = ((imode == MODE_UP_SAT)   && (oCount == CNT_MAX)) ||
                    ((imode == MODE_DOWN_SAT) && (oCount == CNT_ZERO));
    assign oMatch = (oCount == icmp_val);

endmodule

// File: tb/tb_vsync_frame_timer.sv
// tb/tb_vsync_frame_timer.sv - directed scoreboard bench for vsync_frame_timer
module tb_vsync_frame_timer;

    logic       iclk;
    logic       irst;
    logic       ivsync;
    logic       ien;
    logic       iclr;
    logic       iload;
    logic [7:0] iload_val;
    logic [1:0] imode;
    logic [7:0] icmp_val;

    logic [7:0] d_count, s_count, f_count;
    logic       d_tick, s_tick, f_tick;
    logic       d_wrap, s_wrap, f_wrap;
    logic       d_sat, s_sat, f_sat;
    logic       d_match, s_match, f_match;

    int n_assert = 0;
    int n_fail   = 0;

    vsync_frame_timer u_d (
        .iclk(iclk), .irst(irst), .ivsync(ivsync), .ien(ien), .iclr(iclr),
        .iload(iload), .iload_val(iload_val), .imode(imode), .icmp_val(icmp_val),
        .oCount(d_count), .oTick(d_tick), .oWrap(d_wrap), .oSat(d_sat), .oMatch(d_match)
    );

    vsync_frame_timer #(.COUNT_W(8), .MAX_COUNT(5), .FRAMES_PER_TICK(3), .EDGE_SEL(0)) u_s (
        .iclk(iclk), .irst(irst), .ivsync(ivsync), .ien(ien), .iclr(iclr),
        .iload(iload), .iload_val(iload_val), .imode(imode), .icmp_val(icmp_val),
        .oCount(s_count), .oTick(s_tick), .oWrap(s_wrap), .oSat(s_sat), .oMatch(s_match)
    );

    vsync_frame_timer #(.COUNT_W(8), .MAX_COUNT(5), .FRAMES_PER_TICK(3), .EDGE_SEL(1)) u_f (
        .iclk(iclk), .irst(irst), .ivsync(ivsync), .ien(ien), .iclr(iclr),
        .iload(iload), .iload_val(iload_val), .imode(imode), .icmp_val(icmp_val),
        .oCount(f_count), .oTick(f_tick), .oWrap(f_wrap), .oSat(f_sat), .oMatch(f_match)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Pulse counters sampled on the falling edge.
    int d_tn = 0, d_wn = 0, s_tn = 0, s_wn = 0, f_tn = 0, f_wn = 0;
    always @(negedge iclk) begin
        if (d_tick === 1'b1) d_tn <= d_tn + 1;
        if (d_wrap === 1'b1) d_wn <= d_wn + 1;
        if (s_tick === 1'b1) s_tn <= s_tn + 1;
        if (s_wrap === 1'b1) s_wn <= s_wn + 1;
        if (f_tick === 1'b1) f_tn <= f_tn + 1;
        if (f_wrap === 1'b1) f_wn <= f_wn + 1;
    end

    int d_tb, d_wb, s_tb, s_wb, f_tb, f_wb;
    task automatic mark();
        d_tb = d_tn; d_wb = d_wn;
        s_tb = s_tn; s_wb = s_wn;
        f_tb = f_tn; f_wb = f_wn;
    endtask

    localparam int D = 0;
    localparam int S = 10;
    localparam int F = 20;
    localparam int CNT = 0, TCKS = 1, WRPS = 2, SAT = 3, MAT = 4, TCK = 5, WRP = 6;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            D + CNT:  return 32'(d_count);
            D + TCKS: return 32'(d_tn - d_tb);
            D + WRPS: return 32'(d_wn - d_wb);
            D + SAT:  return 32'(d_sat);
            D + MAT:  return 32'(d_match);
            D + TCK:  return 32'(d_tick);
            D + WRP:  return 32'(d_wrap);
            S + CNT:  return 32'(s_count);
            S + TCKS: return 32'(s_tn - s_tb);
            S + WRPS: return 32'(s_wn - s_wb);
            S + SAT:  return 32'(s_sat);
            S + MAT:  return 32'(s_match);
            S + TCK:  return 32'(s_tick);
            S + WRP:  return 32'(s_wrap);
            F + CNT:  return 32'(f_count);
            F + TCKS: return 32'(f_tn - f_tb);
            F + WRPS: return 32'(f_wn - f_wb);
            F + SAT:  return 32'(f_sat);
            F + MAT:  return 32'(f_match);
            F + TCK:  return 32'(f_tick);
            F + WRP:  return 32'(f_wrap);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    task automatic push(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            n_assert++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            ivsync = 1'b1;
            cyc(2);
            ivsync = 1'b0;
            cyc(2);
        end
        cyc(4);
    endtask

    task automatic do_load(input logic [7:0] v);
        iload_val = v;
        iload = 1'b1;
        cyc(1);
        iload = 1'b0;
        cyc(1);
    endtask

    task automatic do_clear();
        iclr = 1'b1;
        cyc(1);
        iclr = 1'b0;
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        irst = 1'b0; ivsync = 1'b0; ien = 1'b1; iclr = 1'b0; iload = 1'b0;
        iload_val = 8'd0; imode = 2'b11; icmp_val = 8'd0;
        cyc(3);
        push("rst_count", D + CNT, 0);
        push("rst_tick",  D + TCK, 0);
        push("rst_wrap",  D + WRP, 0);
        push("rst_match", D + MAT, 1);
        push("rst_sat_down", S + SAT, 1);
        check_sb();
        imode = 2'b00;
        #1;
        push("rst_sat_up", D + SAT, 0);
        check_sb();
        irst = 1'b1;
        cyc(3);

        // 60 frames give one tick, two cycles after the 60th edge is sampled
        mark();
        pulses(59);
        push("t1_no_tick_59", D + TCKS, 0);
        check_sb();
        ivsync = 1'b1;
        cyc(1);
        push("t1_lat_k", D + TCK, 0);
        check_sb();
        cyc(1);
        push("t1_lat_k1", D + TCK, 0);
        check_sb();
        cyc(1);
        push("t1_lat_k2_tick", D + TCK, 1);
        push("t1_lat_k2_count", D + CNT, 1);
        check_sb();
        cyc(1);
        push("t1_tick_1cyc", D + TCK, 0);
        push("t1_ticks", D + TCKS, 1);
        check_sb();
        ivsync = 1'b0;
        cyc(4);

        do_load(8'd253);
        push("t1_load", D + CNT, 253);
        check_sb();
        mark();
        pulses(60);
        push("t1_to_max", D + CNT, 254);
        push("t1_no_wrap", D + WRPS, 0);
        check_sb();
        pulses(60);
        push("t1_wrapped", D + CNT, 0);
        push("t1_wraps", D + WRPS, 1);
        push("t1_ticks2", D + TCKS, 2);
        check_sb();

        // up-saturate on the small instance
        imode = 2'b01;
        do_clear();
        mark();
        pulses(24);
        push("t2_count", S + CNT, 5);
        push("t2_ticks", S + TCKS, 8);
        push("t2_wraps", S + WRPS, 0);
        push("t2_sat", S + SAT, 1);
        push("t2_fall_ticks", F + TCKS, 8);
        check_sb();

        // down-wrap from a loaded value
        imode = 2'b10;
        do_load(8'd2);
        mark();
        pulses(3);
        push("t3_step1", S + CNT, 1);
        check_sb();
        pulses(3);
        push("t3_step2", S + CNT, 0);
        push("t3_no_wrap", S + WRPS, 0);
        check_sb();
        pulses(3);
        push("t3_step3", S + CNT, 5);
        push("t3_wrap", S + WRPS, 1);
        push("t3_ticks", S + TCKS, 3);
        push("t3_nosat", S + SAT, 0);
        check_sb();

        // clear coincident with a terminal edge
        imode = 2'b00;
        pulses(2);
        mark();
        ivsync = 1'b1;
        cyc(2);
        iclr = 1'b1;
        cyc(1);
        iclr = 1'b0;
        push("t4_clr_count", S + CNT, 0);
        push("t4_clr_tick", S + TCK, 0);
        check_sb();
        ivsync = 1'b0;
        cyc(4);
        pulses(2);
        push("t4_clr_restart2", S + TCKS, 0);
        check_sb();
        pulses(1);
        push("t4_clr_restart3", S + TCKS, 1);
        push("t4_clr_count3", S + CNT, 1);
        check_sb();

        // load coincident with a terminal edge
        pulses(2);
        mark();
        ivsync = 1'b1;
        cyc(2);
        iload_val = 8'd4;
        iload = 1'b1;
        cyc(1);
        iload = 1'b0;
        push("t4_ld_count", S + CNT, 4);
        push("t4_ld_tick", S + TCK, 0);
        check_sb();
        ivsync = 1'b0;
        cyc(4);
        pulses(2);
        push("t4_ld_restart2", S + TCKS, 0);
        push("t4_ld_hold", S + CNT, 4);
        check_sb();
        pulses(1);
        push("t4_ld_restart3", S + TCKS, 1);
        push("t4_ld_count3", S + CNT, 5);
        check_sb();

        // enable low holds everything
        ien = 1'b0;
        mark();
        pulses(10);
        push("t5_en_count", S + CNT, 5);
        push("t5_en_ticks", S + TCKS, 0);
        check_sb();
        ien = 1'b1;
        pulses(2);
        push("t5_en_presc_held", S + TCKS, 0);
        check_sb();

        // held level counts once; falling-edge instance waits for the fall
        do_clear();
        mark();
        pulses(2);
        ivsync = 1'b1;
        cyc(50);
        push("t5_hold_s_ticks", S + TCKS, 1);
        push("t5_hold_s_count", S + CNT, 1);
        push("t5_hold_f_ticks", F + TCKS, 0);
        push("t5_hold_f_count", F + CNT, 0);
        check_sb();
        ivsync = 1'b0;
        cyc(5);
        push("t5_fall_f_ticks", F + TCKS, 1);
        push("t5_fall_f_count", F + CNT, 1);
        push("t5_fall_s_ticks", S + TCKS, 1);
        check_sb();

        // compare match
        icmp_val = 8'd3;
        do_load(8'd3);
        push("t5_match_s", S + MAT, 1);
        push("t5_match_d", D + MAT, 1);
        check_sb();
        do_load(8'd2);
        push("t5_nomatch_s", S + MAT, 0);
        check_sb();

        // async reset mid-count and mid-prescale
        icmp_val = 8'd0;
        do_load(8'd100);
        pulses(1);
        @(posedge iclk);
        #3;
        irst = 1'b0;
        #1;
        push("t6_rst_d_count", D + CNT, 0);
        push("t6_rst_s_count", S + CNT, 0);
        push("t6_rst_d_match", D + MAT, 1);
        check_sb();
        cyc(2);
        irst = 1'b1;
        cyc(2);
        mark();
        pulses(2);
        push("t6_restart2", S + TCKS, 0);
        check_sb();
        pulses(1);
        push("t6_restart3", S + TCKS, 1);
        push("t6_restart_count", S + CNT, 1);
        check_sb();

        // load clamping
        do_load(8'd255);
        push("t6_clamp_d", D + CNT, 254);
        push("t6_clamp_s", S + CNT, 5);
        check_sb();
        do_load(8'd7);
        push("t6_load7_d", D + CNT, 7);
        push("t6_load7_s", S + CNT, 5);
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
